// File: rtl/weight_db_ctrl.sv
// weight_db_ctrl
//   Address and handshake control for the weight double buffer. The buffer has
//   two banks. Each bank holds bank_size entries, one entry per address.
//   - The write side fills one bank from the off-chip weight stream.
//   - The read side sweeps the other bank num_reads times for the systolic
//     array, then releases it.
//   - The banks swap roles as fills complete and drains release. A bank is
//     never written again before its final read.
//
// Ports
//   clk, rst_n          clock; synchronous active-low reset
//   config_en           one-cycle pulse: load size/repeat, clear pointers/flags
//   config_bank_size    entries per bank (0 leaves the block unconfigured)
//   config_num_reads    full sweeps per bank (0 leaves the block unconfigured)
//   wr_valid/wr_ready   upstream weight handshake
//   wr_en/wr_bank/wr_addr   write strobe, bank and address into the buffer
//   rd_req/rd_avail     systolic-array read request / drain bank readable
//   rd_en/rd_bank/rd_addr   read strobe, bank and address into the buffer
//   rd_data_valid       rd_en delayed one cycle (SRAM read latency)
//   rd_last             final address of the final sweep of a bank

module weight_db_ctrl #(
  parameter int unsigned BANK_ADDR_WIDTH = 32,
  parameter int unsigned REPEAT_WIDTH    = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       config_en,
  input  logic [BANK_ADDR_WIDTH-1:0] config_bank_size,
  input  logic [REPEAT_WIDTH-1:0]    config_num_reads,
  input  logic                       wr_valid,
  output logic                       wr_ready,
  output logic                       wr_en,
  output logic                       wr_bank,
  output logic [BANK_ADDR_WIDTH-1:0] wr_addr,
  input  logic                       rd_req,
  output logic                       rd_avail,
  output logic                       rd_en,
  output logic                       rd_bank,
  output logic [BANK_ADDR_WIDTH-1:0] rd_addr,
  output logic                       rd_data_valid,
  output logic                       rd_last
);

  localparam logic [BANK_ADDR_WIDTH-1:0] ADDR_ONE  = BANK_ADDR_WIDTH'(1);
  localparam logic [REPEAT_WIDTH-1:0]    SWEEP_ONE = REPEAT_WIDTH'(1);

  logic                       configured;
  logic [BANK_ADDR_WIDTH-1:0] bank_size;
  logic [REPEAT_WIDTH-1:0]    num_reads;
  logic [BANK_ADDR_WIDTH-1:0] last_addr;
  logic [REPEAT_WIDTH-1:0]    last_sweep;
  logic [REPEAT_WIDTH-1:0]    sweep;
  logic [1:0]                 full;
  logic [1:0]                 full_next;
  logic                       wr_last;
  logic                       rd_wrap;
  logic                       rd_release;
  logic                       clear;

  // Both limits are nonzero whenever configured=1. The decrement therefore
  // never wraps on a live path.
  assign last_addr  = bank_size - ADDR_ONE;
  assign last_sweep = num_reads - SWEEP_ONE;

  // Configuration reload clears the same pointers and flags as reset.
  assign clear = !rst_n || config_en;

  always_comb begin
    // Outputs are gated by rst_n so that they read 0 while reset is held.
    wr_ready   = rst_n && configured && !full[wr_bank];
    rd_avail   = rst_n && configured && full[rd_bank];
    wr_en      = wr_valid && wr_ready;
    rd_en      = rd_req && rd_avail;
    wr_last    = wr_en && (wr_addr == last_addr);
    rd_wrap    = rd_en && (rd_addr == last_addr);
    rd_release = rd_wrap && (sweep == last_sweep);
    rd_last    = rd_release;

    // Set first, then clear. If one bank completed and was released in the
    // same cycle, the release wins and the fill is held off.
    full_next = full;
    if (wr_last) begin
      full_next[wr_bank] = 1'b1;
    end
    if (rd_release) begin
      full_next[rd_bank] = 1'b0;
    end
  end

  // Configuration registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      configured <= 1'b0;
      bank_size  <= '0;
      num_reads  <= '0;
    end else if (config_en) begin
      bank_size  <= config_bank_size;
      num_reads  <= config_num_reads;
      configured <= (config_bank_size != '0) && (config_num_reads != '0);
    end
  end

  // Occupancy flags.
  always_ff @(posedge clk) begin
    if (clear) begin
      full <= '0;
    end else begin
      full <= full_next;
    end
  end

  // Write pointer. The address wraps by compare-and-clear, not by overflow.
  always_ff @(posedge clk) begin
    if (clear) begin
      wr_bank <= 1'b0;
      wr_addr <= '0;
    end else if (wr_en) begin
      if (wr_last) begin
        wr_addr <= '0;
        wr_bank <= ~wr_bank;
      end else begin
        wr_addr <= wr_addr + ADDR_ONE;
      end
    end
  end

  // Read pointer and sweep counter.
  always_ff @(posedge clk) begin
    if (clear) begin
      rd_bank <= 1'b0;
      rd_addr <= '0;
      sweep   <= '0;
    end else if (rd_en) begin
      if (rd_wrap) begin
        rd_addr <= '0;
        if (rd_release) begin
          sweep   <= '0;
          rd_bank <= ~rd_bank;
        end else begin
          sweep <= sweep + SWEEP_ONE;
        end
      end else begin
        rd_addr <= rd_addr + ADDR_ONE;
      end
    end
  end

  // Read data arrives one cycle after the strobe.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_data_valid <= 1'b0;
    end else begin
      rd_data_valid <= rd_en;
    end
  end

endmodule

// File: tb/tb_weight_db_ctrl.sv
module tb_weight_db_ctrl;

  localparam int AW = 32;
  localparam int RW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          config_en = 1'b0;
  logic [AW-1:0] config_bank_size = '0;
  logic [RW-1:0] config_num_reads = '0;
  logic          wr_valid = 1'b0;
  logic          wr_ready;
  logic          wr_en;
  logic          wr_bank;
  logic [AW-1:0] wr_addr;
  logic          rd_req = 1'b0;
  logic          rd_avail;
  logic          rd_en;
  logic          rd_bank;
  logic [AW-1:0] rd_addr;
  logic          rd_data_valid;
  logic          rd_last;

  weight_db_ctrl #(
    .BANK_ADDR_WIDTH(AW),
    .REPEAT_WIDTH   (RW)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .config_en       (config_en),
    .config_bank_size(config_bank_size),
    .config_num_reads(config_num_reads),
    .wr_valid        (wr_valid),
    .wr_ready        (wr_ready),
    .wr_en           (wr_en),
    .wr_bank         (wr_bank),
    .wr_addr         (wr_addr),
    .rd_req          (rd_req),
    .rd_avail        (rd_avail),
    .rd_en           (rd_en),
    .rd_bank         (rd_bank),
    .rd_addr         (rd_addr),
    .rd_data_valid   (rd_data_valid),
    .rd_last         (rd_last)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          bank;
    logic [AW-1:0] addr;
    logic          last;
  } acc_t;

  acc_t wq[$];
  acc_t rq[$];
  acc_t mon_e;

  int   errors = 0;
  int   checks = 0;
  int   writes_seen = 0;
  int   lasts_seen = 0;
  int   cur_size = 0;
  logic prev_rd = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push_w_block(input logic bank, input int size);
    acc_t e;
    for (int a = 0; a < size; a++) begin
      e.bank = bank;
      e.addr = AW'(a);
      e.last = 1'b0;
      wq.push_back(e);
    end
  endtask

  task automatic push_r_block(input logic bank, input int size, input int nreads);
    acc_t e;
    for (int s = 0; s < nreads; s++) begin
      for (int a = 0; a < size; a++) begin
        e.bank = bank;
        e.addr = AW'(a);
        e.last = (s == nreads - 1) && (a == size - 1);
        rq.push_back(e);
      end
    end
  endtask

  task automatic clear_board();
    wq.delete();
    rq.delete();
    writes_seen = 0;
    lasts_seen  = 0;
  endtask

  task automatic cfg(input int size, input int nreads);
    config_en        = 1'b1;
    config_bank_size = AW'(size);
    config_num_reads = RW'(nreads);
    clear_board();
    cur_size = size;
    cyc();
    config_en = 1'b0;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    config_en = 1'b0;
    wr_valid  = 1'b0;
    rd_req    = 1'b0;
    clear_board();
    cur_size = 0;
    cyc();
    @(negedge clk);
    chk("rst_hold_wr_ready", wr_ready, 0);
    chk("rst_hold_rd_avail", rd_avail, 0);
    chk("rst_hold_rd_last", rd_last, 0);
    cyc();
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_rd_addr", rd_addr, 0);
    chk("rst_wr_bank", wr_bank, 0);
    chk("rst_rd_bank", rd_bank, 0);
    chk("rst_wr_ready", wr_ready, 0);
    chk("rst_rd_avail", rd_avail, 0);
    chk("rst_rd_data_valid", rd_data_valid, 0);
    cyc();
  endtask

  // Drives the handshakes until every queued write and read has been seen.
  task automatic drain(input bit rnd, input int budget);
    int n;
    n = 0;
    while ((wq.size() != 0 || rq.size() != 0) && n < budget) begin
      wr_valid = (wq.size() != 0) && (rnd ? ($urandom_range(0, 1) == 1) : 1'b1);
      rd_req   = (rq.size() != 0) && (rnd ? ($urandom_range(0, 1) == 1) : 1'b1);
      cyc();
      n++;
    end
    wr_valid = 1'b0;
    rd_req   = 1'b0;
    chk("drain_writes_left", 64'(wq.size()), 0);
    chk("drain_reads_left", 64'(rq.size()), 0);
  endtask

  // Monitor: compares every strobe against the scoreboard queues.
  always @(negedge clk) begin
    chk("rd_data_valid_delay", rd_data_valid, prev_rd);
    chk("wr_en_rule", wr_en, wr_valid && wr_ready);
    chk("rd_en_rule", rd_en, rd_req && rd_avail);
    if (wr_en === 1'b1) begin
      if (wq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: bank %0d addr %0h, none expected at %0t", wr_bank, wr_addr, $time);
      end else begin
        mon_e = wq.pop_front();
        chk("wr_bank", wr_bank, mon_e.bank);
        chk("wr_addr", wr_addr, mon_e.addr);
        if (cur_size > 0) begin
          chk("no_overwrite", 64'((writes_seen / cur_size) <= lasts_seen + 1), 1);
        end
        writes_seen++;
      end
    end
    if (rd_en === 1'b1) begin
      if (rq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_read: bank %0d addr %0h, none expected at %0t", rd_bank, rd_addr, $time);
      end else begin
        mon_e = rq.pop_front();
        chk("rd_bank", rd_bank, mon_e.bank);
        chk("rd_addr", rd_addr, mon_e.addr);
        chk("rd_last", rd_last, mon_e.last);
        if (rd_last === 1'b1) begin
          lasts_seen++;
        end
      end
    end else begin
      chk("rd_last_idle", rd_last, 0);
    end
    prev_rd = rd_en && rst_n;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();

    // Fill both banks with size 4, 2 sweeps; wr_valid held high.
    cfg(4, 2);
    push_w_block(1'b0, 4);
    push_w_block(1'b1, 4);
    wr_valid = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (c == 4) chk("s1_rd_avail_c4", rd_avail, 0);
      if (c == 5) chk("s1_rd_avail_c5", rd_avail, 1);
      if (c == 8) chk("s1_wr_ready_c8", wr_ready, 1);
      if (c == 9) chk("s1_wr_ready_c9", wr_ready, 0);
      cyc();
    end
    wr_valid = 1'b0;

    // Drain bank 0: two sweeps, released after the 8th read.
    push_r_block(1'b0, 4, 2);
    rd_req = 1'b1;
    for (int c = 11; c <= 18; c++) begin
      @(negedge clk);
      cyc();
    end
    rd_req = 1'b0;
    @(negedge clk);
    chk("s2_rd_bank", rd_bank, 1);
    chk("s2_wr_bank", wr_bank, 0);
    chk("s2_wr_ready", wr_ready, 1);
    chk("s2_rd_avail", rd_avail, 1);
    cyc();

    // Bank 1 fill completes in the same cycle as the bank 0 release.
    cfg(4, 1);
    push_w_block(1'b0, 4);
    push_w_block(1'b1, 4);
    push_r_block(1'b0, 4, 1);
    wr_valid = 1'b1;
    rd_req   = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (c == 5) chk("s4_both_active", 64'({wr_en, rd_en}), 64'(2'b11));
      cyc();
    end
    wr_valid = 1'b0;
    rd_req   = 1'b0;
    @(negedge clk);
    chk("s4_rd_bank", rd_bank, 1);
    chk("s4_wr_bank", wr_bank, 0);
    chk("s4_wr_ready", wr_ready, 1);
    chk("s4_rd_avail", rd_avail, 1);
    cyc();

    // Random handshakes: six blocks of 36 entries, three sweeps each.
    cfg(36, 3);
    for (int b = 0; b < 6; b++) begin
      push_w_block(1'(b % 2), 36);
      push_r_block(1'(b % 2), 36, 3);
    end
    drain(1'b1, 20000);
    chk("s3_released_blocks", 64'(lasts_seen), 6);

    // Illegal zero configurations keep both sides closed.
    cfg(0, 2);
    wr_valid = 1'b1;
    rd_req   = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk("s5_size0_wr_ready", wr_ready, 0);
      chk("s5_size0_rd_avail", rd_avail, 0);
      cyc();
    end
    cfg(4, 0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("s5_reads0_wr_ready", wr_ready, 0);
      chk("s5_reads0_rd_avail", rd_avail, 0);
      cyc();
    end
    wr_valid = 1'b0;
    rd_req   = 1'b0;

    // Size 1, single read: rd_last on every read, banks alternate.
    cfg(1, 1);
    for (int k = 0; k < 6; k++) begin
      push_w_block(1'(k % 2), 1);
      push_r_block(1'(k % 2), 1, 1);
    end
    drain(1'b0, 50);
    chk("s5_size1_lasts", 64'(lasts_seen), 6);

    // Reset asserted mid-fill at wr_addr=2.
    cfg(4, 1);
    push_w_block(1'b0, 2);
    wr_valid = 1'b1;
    for (int c = 1; c <= 2; c++) begin
      @(negedge clk);
      cyc();
    end
    rst_n = 1'b0;
    @(negedge clk);
    chk("s6_addr_before_rst", wr_addr, 2);
    chk("s6_rst_wr_en", wr_en, 0);
    chk("s6_rst_wr_ready", wr_ready, 0);
    cyc();
    rst_n    = 1'b1;
    wr_valid = 1'b0;
    clear_board();
    @(negedge clk);
    chk("s6_wr_addr", wr_addr, 0);
    chk("s6_wr_bank", wr_bank, 0);
    chk("s6_rd_addr", rd_addr, 0);
    chk("s6_wr_ready", wr_ready, 0);
    chk("s6_rd_avail", rd_avail, 0);
    chk("s6_rd_data_valid", rd_data_valid, 0);
    cyc();
    cfg(4, 1);
    push_w_block(1'b0, 4);
    push_r_block(1'b0, 4, 1);
    drain(1'b0, 50);

    repeat (2) cyc();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/weight_db_ctrl.md
Name: weight_db_ctrl

Overview:
- Control for the weight double buffer: two banks, each holding OC1 x IC1 x FY x FX x IC0 entries, one entry per address.
- Write side: accepts the off-chip weight stream through a valid/ready handshake and writes it into the "fill" bank.
- Read side: sweeps the "drain" bank for the systolic array, a configurable number of times per weight block.
- The two banks swap roles when a fill completes and a drain completes; no entry is overwritten before its last read.

Parameters:
- BANK_ADDR_WIDTH, 32, width of bank size config and of both addresses.
- REPEAT_WIDTH, 16, width of the read-sweep repeat count.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; synchronous, active-low.
- config_en  in  1  one-cycle pulse; loads config_bank_size and config_num_reads.
- config_bank_size  in  BANK_ADDR_WIDTH  entries per bank (OC1*IC1*FY*FX*IC0); 0 is illegal.
- config_num_reads  in  REPEAT_WIDTH  full sweeps of a bank before it is released; 0 is illegal.
- wr_valid  in  1  upstream weight word valid.
- wr_ready  out  1  fill bank has space; a word transfers when wr_valid && wr_ready.
- wr_en  out  1  write strobe to the buffer; equals wr_valid && wr_ready.
- wr_bank  out  1  bank being filled.
- wr_addr  out  BANK_ADDR_WIDTH  write address within wr_bank.
- rd_req  in  1  systolic array requests one read.
- rd_avail  out  1  drain bank is full and readable.
- rd_en  out  1  read strobe; equals rd_req && rd_avail.
- rd_bank  out  1  bank being drained.
- rd_addr  out  BANK_ADDR_WIDTH  read address within rd_bank.
- rd_data_valid  out  1  rd_en delayed one cycle (1-cycle SRAM latency).
- rd_last  out  1  high with rd_en on the final address of the final sweep.

Behaviour:
- Reset (rst_n=0 at a clk edge) clears:
  - configured flag, bank sizes, both full[1:0] flags;
  - wr_bank=0, rd_bank=0, wr_addr=0, rd_addr=0;
  - sweep count=0, rd_data_valid=0.
- Outputs during reset: wr_ready=0, rd_avail=0, wr_en=0, rd_en=0, rd_last=0.
- Reset mid-transfer discards all buffer state; upstream must resend the block.
- Configuration:
  - config_en registers size and repeat and sets configured=1.
  - It also performs the same pointer/flag clear as reset.
  - The new values take effect the next cycle.
  - A zero in either field leaves configured=0.
  - While configured=0: wr_ready=0 and rd_avail=0.
- Write side:
  - wr_ready = configured && !full[wr_bank].
  - On each transfer, wr_addr increments.
  - When wr_addr == size-1 on a transfer: wr_addr -> 0, full[wr_bank] <- 1, wr_bank toggles.
- Read side:
  - rd_avail = configured && full[rd_bank].
  - On each rd_en, rd_addr increments.
  - When rd_addr == size-1: rd_addr -> 0 and the sweep count increments.
  - Final sweep (count == num_reads-1) at the last address:
    - rd_last=1;
    - full[rd_bank] <- 0, rd_bank toggles, sweep count -> 0.
- Same cycle, both events: a write completing bank X and a read releasing bank Y.
  - Both flag updates apply.
  - If X==Y (size 1 edge case), the release wins and the fill is held off a cycle.
  - In practice X!=Y: set full[X] and clear full[Y] together.
- Full/empty boundaries:
  - Both banks full -> wr_ready=0 until a release.
  - Both banks empty -> rd_avail=0.
  - A released bank becomes writable the cycle after release.
  - A completed bank becomes readable the cycle after completion.
- rd_req while rd_avail=0 and wr_valid while wr_ready=0 are ignored: no pointer change, no strobe.
- Counter arithmetic: modulo via explicit compare-and-clear, never natural overflow. Size up to 2^BANK_ADDR_WIDTH-1.

Test Plan:
- Reset then config size=4, reads=2; hold wr_valid=1 -> wr_addr 0,1,2,3 on bank 0, then 0..3 on bank 1; wr_ready drops after 8 transfers; rd_avail=1 from cycle 5.
- Continuing from the previous scenario, hold rd_req=1 -> rd_addr 0,1,2,3,0,1,2,3 on bank 0; rd_last on 8th read; rd_bank->1; wr_ready=1 next cycle with wr_bank=0; rd_data_valid trails rd_en by 1.
- Random wr_valid/rd_req toggling (size=36, reads=3) across 6 blocks -> scoreboard: every written word read exactly 3 times, in address order, never overwritten before its last read.
- Simultaneous completion: bank 1 fill ends the same cycle bank 0 drain ends -> next cycle full=2'b10, rd_bank=1, wr_bank=0, wr_ready=1.
- Config size=0 -> wr_ready=0 and rd_avail=0 indefinitely; then config size=1, reads=1 -> each word readable once, rd_last every read.
- Assert rst_n=0 mid-fill at wr_addr=2 -> next cycle all outputs 0; after reconfig, fill restarts at bank 0, addr 0.
